// File: rtl/clk_rst_sequencer.sv
// Power-up / relock sequencer for the DCM clock chain: pulses dcmRst, waits for lock,
// holds sysRst through a settle window. Optional RETRY_LIMIT_EN macro adds a latched FAULT state.
module clk_rst_sequencer #(
    parameter int DCM_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 7,
    parameter int RETRY_W        = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lockedIn,
    output logic               dcmRst,
    output logic               sysRst,
    output logic               ready,
    output logic [RETRY_W-1:0] retryCount,
    output logic               fault
);

    localparam int MAX_AB  = (DCM_RST_CYCLES > LOCK_TIMEOUT) ? DCM_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DCM_LAST    = CNT_W'(DCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

`ifdef RETRY_LIMIT_EN
    typedef enum logic [2:0] {
        DCMRST = 3'd0, WAIT = 3'd1, SETTLE = 3'd2, RUN = 3'd3, FAULT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        DCMRST = 3'd0, WAIT = 3'd1, SETTLE = 3'd2, RUN = 3'd3
    } state_t;
`endif

    state_t             state;
    state_t             retryTarget;
    logic [CNT_W-1:0]   counter;
    logic [RETRY_W-1:0] retryNext;
    logic               lockMeta;
    logic               lockSync;

    // {dcmRst, sysRst, ready, fault} for the state being entered
    function automatic logic [3:0] outsFor(input state_t s);
        case (s)
            DCMRST:  return 4'b1100;
            WAIT:    return 4'b0100;
            SETTLE:  return 4'b0100;
            RUN:     return 4'b0010;
`ifdef RETRY_LIMIT_EN
            FAULT:   return 4'b1101;
`endif
            default: return 4'b1100;
        endcase
    endfunction

    function automatic logic [RETRY_W-1:0] bumpRetry(input logic [RETRY_W-1:0] cnt);
        if (cnt == {RETRY_W{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + RETRY_W'(1);
        end
    endfunction

    assign retryNext = bumpRetry(retryCount);

`ifdef RETRY_LIMIT_EN
    assign retryTarget = (retryNext == RETRY_W'(MAX_RETRIES)) ? FAULT : DCMRST;
`else
    // The retry limit only matters when the FAULT state is built in
    logic unusedParams;
    assign unusedParams = (MAX_RETRIES > 0);
    assign retryTarget  = DCMRST;
`endif

    // Two-flop synchronizer: lockedIn comes from the DCM domain, asynchronous to clk
    always_ff @(posedge clk) begin
        if (rst) begin
            lockMeta <= 1'b0;
            lockSync <= 1'b0;
        end else begin
            lockMeta <= lockedIn;
            lockSync <= lockMeta;
        end
    end

    // Sequencer FSM; outputs are loaded from the state entered on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state                          <= DCMRST;
            counter                        <= {CNT_W{1'b0}};
            retryCount                     <= {RETRY_W{1'b0}};
            {dcmRst, sysRst, ready, fault} <= outsFor(DCMRST);
        end else begin
            case (state)
                DCMRST: begin
                    if (counter == DCM_LAST) begin
                        state                          <= WAIT;
                        counter                        <= {CNT_W{1'b0}};
                        {dcmRst, sysRst, ready, fault} <= outsFor(WAIT);
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                WAIT: begin
                    // Lock wins over a coincident timeout
                    if (lockSync) begin
                        state                          <= SETTLE;
                        counter                        <= {CNT_W{1'b0}};
                        {dcmRst, sysRst, ready, fault} <= outsFor(SETTLE);
                    end else if (counter == LOCK_LAST) begin
                        state                          <= retryTarget;
                        counter                        <= {CNT_W{1'b0}};
                        retryCount                     <= retryNext;
                        {dcmRst, sysRst, ready, fault} <= outsFor(retryTarget);
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (!lockSync) begin
                        state                          <= retryTarget;
                        counter                        <= {CNT_W{1'b0}};
                        retryCount                     <= retryNext;
                        {dcmRst, sysRst, ready, fault} <= outsFor(retryTarget);
                    end else if (counter == SETTLE_LAST) begin
                        state                          <= RUN;
                        counter                        <= {CNT_W{1'b0}};
                        retryCount                     <= {RETRY_W{1'b0}};
                        {dcmRst, sysRst, ready, fault} <= outsFor(RUN);
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                RUN: begin
                    // Lock loss in RUN restarts the chain without counting as a retry
                    if (!lockSync) begin
                        state                          <= DCMRST;
                        counter                        <= {CNT_W{1'b0}};
                        {dcmRst, sysRst, ready, fault} <= outsFor(DCMRST);
                    end else begin
                        counter <= {CNT_W{1'b0}};
                    end
                end
`ifdef RETRY_LIMIT_EN
                FAULT: begin
                    counter <= {CNT_W{1'b0}};
                end
`endif
                default: begin
                    state                          <= DCMRST;
                    counter                        <= {CNT_W{1'b0}};
                    {dcmRst, sysRst, ready, fault} <= outsFor(DCMRST);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer with short timing parameters.
// Build with +define+RETRY_LIMIT_EN to exercise the FAULT path.
module tb_clk_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       lockedIn;
    logic       dcmRst;
    logic       sysRst;
    logic       ready;
    logic [2:0] retryCount;
    logic       fault;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    clk_rst_sequencer #(
        .DCM_RST_CYCLES(4),
        .LOCK_TIMEOUT  (32),
        .SETTLE_CYCLES (16),
        .MAX_RETRIES   (3),
        .RETRY_W       (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lockedIn  (lockedIn),
        .dcmRst    (dcmRst),
        .sysRst    (sysRst),
        .ready     (ready),
        .retryCount(retryCount),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOuts(input string tag, input logic expDcm, input logic expSys,
                             input logic expReady, input logic [2:0] expRetry, input logic expFault);
        check({tag, ".dcmRst"},     {31'd0, dcmRst}, {31'd0, expDcm});
        check({tag, ".sysRst"},     {31'd0, sysRst}, {31'd0, expSys});
        check({tag, ".ready"},      {31'd0, ready},  {31'd0, expReady});
        check({tag, ".retryCount"}, {29'd0, retryCount}, {29'd0, expRetry});
        check({tag, ".fault"},      {31'd0, fault},  {31'd0, expFault});
    endtask

    initial begin
        // Test 1: power-up sequence
        rst      = 1'b1;
        lockedIn = 1'b0;
        tick(2);
        checkOuts("reset", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        tick(3);
        checkOuts("t1_dcm_last", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        tick(1);
        checkOuts("t1_wait", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        tick(5);
        lockedIn = 1'b1;
        tick(18);
        checkOuts("t1_edge18", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        tick(1);
        checkOuts("t1_edge19", 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);

        // Test 3: one-cycle lock drop in RUN
        lockedIn = 1'b0;
        tick(1);
        lockedIn = 1'b1;
        tick(1);
        checkOuts("t3_edge2", 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        tick(1);
        checkOuts("t3_edge3", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        tick(3);
        checkOuts("t3_dcm_last", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        tick(1);
        checkOuts("t3_wait", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        tick(16);
        checkOuts("t3_settling", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        tick(1);
        checkOuts("t3_relock", 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);

        // Test 6: reset asserted while in RUN
        rst = 1'b1;
        tick(1);
        checkOuts("t6_reset_in_run", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        rst      = 1'b0;
        lockedIn = 1'b0;

        // Test 2: two timeouts, lock on the third attempt
        tick(35);
        checkOuts("t2_before_to1", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        tick(1);
        checkOuts("t2_timeout1", 1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
        tick(35);
        checkOuts("t2_before_to2", 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
        tick(1);
        checkOuts("t2_timeout2", 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
        tick(4);
        checkOuts("t2_wait3", 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        lockedIn = 1'b1;
        tick(18);
        checkOuts("t2_settling", 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        tick(1);
        checkOuts("t2_run", 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);

        // Test 4: lock lost part-way through SETTLE
        lockedIn = 1'b0;
        tick(1);
        lockedIn = 1'b1;
        tick(2);
        checkOuts("t4_drop", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        tick(5);
        checkOuts("t4_settle_entry", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        tick(7);
        lockedIn = 1'b0;
        tick(2);
        checkOuts("t4_before_abort", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        tick(1);
        checkOuts("t4_abort", 1'b1, 1'b1, 1'b0, 3'd1, 1'b0);

        // Test 5: lock never arrives
        rst = 1'b1;
        tick(1);
        checkOuts("t5_reset", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        tick(107);
        checkOuts("t5_before_to3", 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        tick(1);
`ifdef RETRY_LIMIT_EN
        checkOuts("t5_fault", 1'b1, 1'b1, 1'b0, 3'd3, 1'b1);
        tick(100);
        checkOuts("t5_fault_held", 1'b1, 1'b1, 1'b0, 3'd3, 1'b1);
`else
        checkOuts("t5_timeout3", 1'b1, 1'b1, 1'b0, 3'd3, 1'b0);
        tick(143);
        checkOuts("t5_before_to7", 1'b0, 1'b1, 1'b0, 3'd6, 1'b0);
        tick(1);
        checkOuts("t5_timeout7", 1'b1, 1'b1, 1'b0, 3'd7, 1'b0);
        tick(36);
        checkOuts("t5_saturated", 1'b1, 1'b1, 1'b0, 3'd7, 1'b0);
`endif
        rst = 1'b1;
        tick(1);
        checkOuts("t5_final_reset", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
